// File: rtl/tlc_monitor.sv
// Passive checker for traffic-light lamp outputs: decodes phase, tracks lock to the legal
// cycle, flags sequence/dwell errors. Define TLC_MON_STICKY_EN to add the err_sticky port.
module tlc_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 8,
  parameter int ERR_W     = 8,
  parameter int CYC_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  output logic [2:0]       phase,
  output logic             locked,
  output logic             err_seq,
  output logic             err_dwell,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CYC_W-1:0] cycle_cnt
`ifdef TLC_MON_STICKY_EN
  ,
  output logic             err_sticky
`endif
);

  typedef enum logic [2:0] {
    PH_IDLE = 3'b000,
    PH_R    = 3'b001,
    PH_RY   = 3'b010,
    PH_G    = 3'b011,
    PH_GY   = 3'b100,
    PH_BAD  = 3'b111
  } phase_e;

  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  localparam int DW_W = $clog2(MAX_DWELL + 2);
  localparam logic [DW_W-1:0] DW_MIN = DW_W'(MIN_DWELL);
  localparam logic [DW_W-1:0] DW_MAX = DW_W'(MAX_DWELL);
  localparam logic [DW_W-1:0] DW_SAT = DW_W'(MAX_DWELL + 1);

  phase_e            phase_q, dec;
  lock_e             state_q, state_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic              seq_q, seq_d, dw_q, dw_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              changed, legal, active;

  always_comb begin
    case ({red, yellow, green})
      3'b000:  dec = PH_IDLE;
      3'b100:  dec = PH_R;
      3'b110:  dec = PH_RY;
      3'b001:  dec = PH_G;
      3'b011:  dec = PH_GY;
      default: dec = PH_BAD;
    endcase
  end

  assign changed = (dec != phase_q);
  assign legal   = changed && ((phase_q == PH_IDLE && dec == PH_R)  ||
                               (phase_q == PH_R    && dec == PH_RY) ||
                               (phase_q == PH_RY   && dec == PH_G)  ||
                               (phase_q == PH_G    && dec == PH_GY) ||
                               (phase_q == PH_GY   && dec == PH_R));
  // Dwell rules only apply to a real lamp phase while the sequence is trusted.
  assign active  = (state_q == LOCKED) && (phase_q != PH_IDLE) && (phase_q != PH_BAD);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    dwell_d   = dwell_q;
    seq_d     = 1'b0;
    dw_d      = 1'b0;
    err_cnt_d = err_cnt_q;
    cyc_d     = cyc_q;

    if (changed)
      dwell_d = DW_W'(1);
    else if (dwell_q != DW_SAT)
      dwell_d = dwell_q + DW_W'(1);

    if (dec == PH_BAD) begin
      if (changed) begin
        seq_d   = 1'b1;
        state_d = UNLOCKED;
      end
    end else if (changed) begin
      if (dec == PH_IDLE) begin
        state_d = UNLOCKED;
      end else if (legal) begin
        if (dec == PH_R) begin
          state_d = LOCKED;
          if (state_q == LOCKED && phase_q == PH_GY)
            cyc_d = cyc_q + CYC_W'(1);
        end
      end else if (state_q == LOCKED) begin
        seq_d   = 1'b1;
        state_d = UNLOCKED;
      end
    end

    if (active) begin
      if (changed && dwell_q < DW_MIN)
        dw_d = 1'b1;
      if (!changed && dwell_q == DW_MAX)
        dw_d = 1'b1;
    end

    if ((seq_d || dw_d) && err_cnt_q != '1)
      err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  // NOTE: state registers use non-blocking assignments and an async reset in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= PH_IDLE;
      state_q   <= UNLOCKED;
      dwell_q   <= '0;
      seq_q     <= 1'b0;
      dw_q      <= 1'b0;
      err_cnt_q <= '0;
      cyc_q     <= '0;
    end else begin
      phase_q   <= dec;
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      seq_q     <= seq_d;
      dw_q      <= dw_d;
      err_cnt_q <= err_cnt_d;
      cyc_q     <= cyc_d;
    end
  end

`ifdef TLC_MON_STICKY_EN
  logic sticky_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sticky_q <= 1'b0;
    else if (seq_d || dw_d)
      sticky_q <= 1'b1;
  end
  assign err_sticky = sticky_q;
`endif

  assign phase     = phase_q;
  assign locked    = (state_q == LOCKED);
  assign err_seq   = seq_q;
  assign err_dwell = dw_q;
  assign err_cnt   = err_cnt_q;
  assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_tlc_monitor.sv
// Directed self-checking bench for tlc_monitor: default, MIN_DWELL=2 and ERR_W=2 instances.
module tb_tlc_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [2:0] l0 = 3'b000, l1 = 3'b000, l2 = 3'b000;
  logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;

  logic [2:0]  ph0, ph1, ph2;
  logic        lk0, lk1, lk2, es0, es1, es2, ed0, ed1, ed2;
  logic [7:0]  ec0, ec1;
  logic [1:0]  ec2;
  logic [15:0] cc0, cc1, cc2;
`ifdef TLC_MON_STICKY_EN
  logic st0, st1, st2;
`endif

  tlc_monitor u_dut (
    .clk(clk), .reset(rst0), .red(l0[2]), .yellow(l0[1]), .green(l0[0]),
    .phase(ph0), .locked(lk0), .err_seq(es0), .err_dwell(ed0), .err_cnt(ec0), .cycle_cnt(cc0)
`ifdef TLC_MON_STICKY_EN
    , .err_sticky(st0)
`endif
  );

  tlc_monitor #(.MIN_DWELL(2)) u_min2 (
    .clk(clk), .reset(rst1), .red(l1[2]), .yellow(l1[1]), .green(l1[0]),
    .phase(ph1), .locked(lk1), .err_seq(es1), .err_dwell(ed1), .err_cnt(ec1), .cycle_cnt(cc1)
`ifdef TLC_MON_STICKY_EN
    , .err_sticky(st1)
`endif
  );

  tlc_monitor #(.ERR_W(2)) u_err2 (
    .clk(clk), .reset(rst2), .red(l2[2]), .yellow(l2[1]), .green(l2[0]),
    .phase(ph2), .locked(lk2), .err_seq(es2), .err_dwell(ed2), .err_cnt(ec2), .cycle_cnt(cc2)
`ifdef TLC_MON_STICKY_EN
    , .err_sticky(st2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_phase(input logic [2:0] lamps);
    case (lamps)
      3'b000:  return 3'b000;
      3'b100:  return 3'b001;
      3'b110:  return 3'b010;
      3'b001:  return 3'b011;
      3'b011:  return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  task automatic step0(input logic [2:0] v);
    l0 = v; @(posedge clk); #1;
  endtask
  task automatic step1(input logic [2:0] v);
    l1 = v; @(posedge clk); #1;
  endtask
  task automatic step2(input logic [2:0] v);
    l2 = v; @(posedge clk); #1;
  endtask

  logic [2:0] loop_seq [4] = '{3'b100, 3'b110, 3'b001, 3'b011};
  logic [2:0] err_seq_v [11] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100,
                                 3'b001, 3'b101, 3'b000, 3'b100, 3'b001};

  initial begin
    // ---- reset state, all instances
    @(posedge clk); #1;
    check("rst_phase", ph0, 0);
    check("rst_locked", lk0, 0);
    check("rst_err_seq", es0, 0);
    check("rst_err_dwell", ed0, 0);
    check("rst_err_cnt", ec0, 0);
    check("rst_cycle_cnt", cc0, 0);
`ifdef TLC_MON_STICKY_EN
    check("rst_sticky", st0, 0);
`endif
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // ---- 1: two clean loops, then R closes the second cycle
    step0(3'b000);
    check("t1_idle_phase", ph0, 0);
    check("t1_idle_locked", lk0, 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        step0(loop_seq[i]);
        check("t1_phase", ph0, exp_phase(loop_seq[i]));
        check("t1_locked", lk0, 1);
        check("t1_no_err", {es0, ed0}, 0);
      end
    end
    check("t1_cycle_before", cc0, 1);
    step0(3'b100);
    check("t1_cycle_cnt", cc0, 2);
    check("t1_err_cnt", ec0, 0);

    // ---- 2: illegal R->G while locked
    step0(3'b001);
    check("t2_err_seq", es0, 1);
    check("t2_locked", lk0, 0);
    check("t2_err_cnt", ec0, 1);
    check("t2_phase", ph0, 3'b011);
`ifdef TLC_MON_STICKY_EN
    check("t2_sticky", st0, 1);
`endif
    step0(3'b001);
    check("t2_pulse_end", es0, 0);

    // ---- 3: BAD held 5 samples
    step0(3'b101);
    check("t3_phase", ph0, 3'b111);
    check("t3_err_seq", es0, 1);
    for (int i = 0; i < 4; i++) begin
      step0(3'b101);
      check("t3_no_repeat", es0, 0);
    end
    check("t3_err_cnt", ec0, 2);

    // ---- 4b: G held 9 samples -> too-long dwell once on the 9th
    step0(3'b000);
    step0(3'b100);
    step0(3'b110);
    for (int i = 1; i <= 9; i++) begin
      step0(3'b001);
      check("t4_dwell_long", ed0, (i == 9) ? 1 : 0);
    end
    check("t4_long_no_seq", es0, 0);
    check("t4_long_locked", lk0, 1);
    check("t4_long_err_cnt", ec0, 3);
    step0(3'b001);
    check("t4_long_once", ed0, 0);

    // ---- 6: three clean loops after an error; sticky holds until reset
    step0(3'b000);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++)
        step0(loop_seq[i]);
    step0(3'b100);
    check("t6_cycle_cnt", cc0, 5);
    check("t6_err_cnt", ec0, 3);
    check("t6_locked", lk0, 1);
`ifdef TLC_MON_STICKY_EN
    check("t6_sticky_held", st0, 1);
`endif
    rst0 = 1'b1; #1;
    check("t6_rst_cycle", cc0, 0);
    check("t6_rst_err_cnt", ec0, 0);
`ifdef TLC_MON_STICKY_EN
    check("t6_rst_sticky", st0, 0);
`endif

    // ---- 4a: MIN_DWELL=2, R held one sample then RY
    step1(3'b000);
    step1(3'b100);
    check("t4_min_locked_r", lk1, 1);
    step1(3'b110);
    check("t4_dwell_short", ed1, 1);
    check("t4_short_no_seq", es1, 0);
    check("t4_short_locked", lk1, 1);
    check("t4_short_err_cnt", ec1, 1);
    step1(3'b110);
    step1(3'b001);
    check("t4_dwell_ok", ed1, 0);

    // ---- 5: ERR_W=2 saturation, then async reset mid-loop
    for (int i = 0; i < 11; i++) begin
      step2(err_seq_v[i]);
      if (i == 2) check("t5_cnt_first", ec2, 1);
      if (i == 6) check("t5_cnt_third", ec2, 3);
    end
    check("t5_err_seq_last", es2, 1);
    check("t5_err_cnt_sat", ec2, 3);
    step2(3'b000);
    step2(3'b100);
    step2(3'b110);
    check("t5_locked_pre", lk2, 1);
    rst2 = 1'b1; #1;
    check("t5_rst_phase", ph2, 0);
    check("t5_rst_locked", lk2, 0);
    check("t5_rst_pulses", {es2, ed2}, 0);
    check("t5_rst_err_cnt", ec2, 0);
    check("t5_rst_cycle", cc2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
